lfsr_cipher_engine: RTL and testbench

Parametrised LFSR stream-cipher engine: a hardware successor to the software encrypt/decrypt programs run on the processor. It encrypts a message into a fixed-length padded frame, or decrypts such a frame back to the message, at one byte per cycle. It sits beside `data_mem` as a streaming accelerator; a DMA/sequencer feeds bytes in and drains bytes out.

---
 rtl/lfsr_pkg.sv | 33 +++
 rtl/lfsr_keygen.sv | 32 +++
 rtl/lfsr_cipher_engine.sv | 190 +++++++++++++++++++
 tb/tb_lfsr_cipher_engine.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM/mode types, pad character and the LFSR step helper
// used by the cipher engine and its keystream generator.
package lfsr_pkg;

    // S_IDLE wait start | S_PRE lead pad | S_BODY message | S_POST tail pad | S_FIN done pulse
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_BODY = 3'd2,
        S_POST = 3'd3,
        S_FIN  = 3'd4
    } lfsr_state_t;

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } lfsr_mode_t;

    localparam logic [7:0] PAD_CHAR   = 8'h20;
    localparam int         LFSR_MAX_W = 16;

    // Left shift with the tap parity entering at bit 0, masked to the live width w.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    w
    );
        logic [LFSR_MAX_W-1:0] mask;
        mask = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - w);
        return ((state << 1) | {{(LFSR_MAX_W-1){1'b0}}, ^(state & taps)}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_keygen.sv
// lfsr_keygen: W-bit Fibonacci-style LFSR; loads the seed, advances once per
// frame position and exposes the low DW bits as keystream.
module lfsr_keygen
    import lfsr_pkg::*;
#(
    parameter int W  = 8,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          load,
    input  logic [W-1:0]  seed,
    input  logic [W-1:0]  taps,
    input  logic          adv,
    output logic [DW-1:0] ks
);

    logic [W-1:0] r_lfsr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_lfsr <= '0;
        end else if (load) begin
            r_lfsr <= seed;
        end else if (adv) begin
            r_lfsr <= W'(lfsr_next(LFSR_MAX_W'(r_lfsr), LFSR_MAX_W'(taps), W));
        end
    end

    assign ks = r_lfsr[DW-1:0];

endmodule

// File: rtl/lfsr_cipher_engine.sv
// lfsr_cipher_engine: streaming LFSR encrypt/decrypt of a padded frame, one byte per cycle.
// Optional LFSR_STRIP_SPACE_EN drops leading pad bytes from the decrypted message body.
module lfsr_cipher_engine
    import lfsr_pkg::*;
#(
    parameter int W         = 8,
    parameter int DW        = 8,
    parameter int MSG_LEN   = 41,
    parameter int FRAME_LEN = 64
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          start,
    input  logic          mode,
    input  logic [W-1:0]  taps,
    input  logic [W-1:0]  seed,
    input  logic [7:0]    pre_len,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    out_count
);

    localparam logic [7:0]    PAD_ROOM = 8'(FRAME_LEN - MSG_LEN);
    localparam logic [7:0]    BODY_LEN = 8'(MSG_LEN);
    localparam logic [DW-1:0] PAD_DW   = DW'(PAD_CHAR);

    lfsr_state_t   r_state, w_state_nxt;
    lfsr_mode_t    r_mode;
    logic [W-1:0]  r_taps;
    logic [7:0]    r_cnt, w_cnt_nxt;
    logic [7:0]    r_post_len;
    logic          r_tail, w_tail_nxt;
    logic          r_err;
    logic [DW-1:0] r_out_data;
    logic          r_out_valid;
    logic [7:0]    r_out_cnt;

    logic [DW-1:0] w_ks, w_byte;
    logic          w_start_ok, w_cfg_bad, w_active, w_consume, w_discard;
    logic          w_out_free, w_in_ready, w_step, w_drop, w_emit;

    assign w_start_ok = start && (r_state == S_IDLE);
    assign w_cfg_bad  = pre_len > PAD_ROOM;
    // r_tail: every position is done, only the output register still has to drain
    assign w_active   = ((r_state == S_PRE) || (r_state == S_BODY) || (r_state == S_POST)) && !r_tail;
    assign w_consume  = (r_mode == DEC) || (r_state == S_BODY);
    assign w_discard  = (r_mode == DEC) && (r_state != S_BODY);
    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_ready = w_active && w_consume && (w_discard || w_out_free);
    assign w_step     = w_active && (w_consume ? (in_valid && w_in_ready) : w_out_free);
    assign w_byte     = (w_consume ? in_data : PAD_DW) ^ w_ks;

`ifdef LFSR_STRIP_SPACE_EN
    logic r_strip;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_strip <= 1'b0;
        end else if (w_start_ok) begin
            r_strip <= (mode == DEC);
        end else if (w_step && (r_state == S_BODY) && (w_byte != PAD_DW)) begin
            r_strip <= 1'b0;
        end
    end

    assign w_drop = r_strip && (r_mode == DEC) && (r_state == S_BODY) && (w_byte == PAD_DW);
`else
    assign w_drop = 1'b0;
`endif

    assign w_emit = w_step && !w_drop && ((r_mode == ENC) || (r_state == S_BODY));

    lfsr_keygen #(.W(W), .DW(DW)) u_keygen (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (w_start_ok),
        .seed  (seed),
        .taps  (r_taps),
        .adv   (w_step),
        .ks    (w_ks)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tail_nxt  = r_tail;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_tail_nxt = 1'b0;
                    if (w_cfg_bad) begin
                        // Bad config parks in POST with nothing left, so FIN follows at once
                        w_state_nxt = S_POST;
                        w_cnt_nxt   = '0;
                        w_tail_nxt  = 1'b1;
                    end else if (pre_len != 8'd0) begin
                        w_state_nxt = S_PRE;
                        w_cnt_nxt   = pre_len;
                    end else begin
                        w_state_nxt = S_BODY;
                        w_cnt_nxt   = BODY_LEN;
                    end
                end
            end
            S_PRE, S_BODY, S_POST: begin
                if (r_tail) begin
                    if (w_out_free) begin
                        w_state_nxt = S_FIN;
                        w_tail_nxt  = 1'b0;
                    end
                end else if (w_step) begin
                    if (r_cnt != 8'd1) begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end else begin
                        w_cnt_nxt = '0;
                        if (r_state == S_PRE) begin
                            w_state_nxt = S_BODY;
                            w_cnt_nxt   = BODY_LEN;
                        end else if ((r_state == S_BODY) && (r_post_len != 8'd0)) begin
                            w_state_nxt = S_POST;
                            w_cnt_nxt   = r_post_len;
                        end else begin
                            w_tail_nxt = 1'b1;
                        end
                    end
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_tail     <= 1'b0;
            r_mode     <= ENC;
            r_taps     <= '0;
            r_post_len <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tail  <= w_tail_nxt;
            if (w_start_ok) begin
                r_mode     <= lfsr_mode_t'(mode);
                r_taps     <= taps;
                r_post_len <= PAD_ROOM - pre_len;
                r_err      <= w_cfg_bad;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_cnt   <= '0;
        end else begin
            if (w_emit) begin
                r_out_data  <= w_byte;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_start_ok) begin
                r_out_cnt <= '0;
            end else if (r_out_valid && out_ready) begin
                r_out_cnt <= r_out_cnt + 8'd1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign err       = r_err;
    assign out_count = r_out_cnt;

endmodule

// File: tb/tb_lfsr_cipher_engine.sv
// tb_lfsr_cipher_engine: randomized self-checking bench for lfsr_cipher_engine against a
// frame-level reference model; honours LFSR_STRIP_SPACE_EN when it is defined.
module tb_lfsr_cipher_engine;

    localparam int MSG_LEN   = 41;
    localparam int FRAME_LEN = 64;
`ifdef LFSR_STRIP_SPACE_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic       CLK = 1'b0, RESET = 1'b1, start = 1'b0, mode = 1'b0;
    logic [7:0] taps = '0, seed = '0, pre_len = '0, in_data = '0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, busy, done, err;
    logic [7:0] out_data, out_count;

    int n_checks = 0, n_fail = 0;

    logic [7:0] g_msg[$], g_in[$], g_out[$], g_exp[$], g_frame[$];
    int r_stall_err, r_done_cnt, r_busy_after;
    bit r_timeout;

    always #5 CLK = ~CLK;

    lfsr_cipher_engine #(.W(8), .DW(8), .MSG_LEN(MSG_LEN), .FRAME_LEN(FRAME_LEN)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .mode(mode), .taps(taps), .seed(seed),
        .pre_len(pre_len), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .done(done), .err(err), .out_count(out_count)
    );

    // Reference: parity of the tapped bits becomes the new LSB of a doubled state.
    function automatic logic [7:0] model_step(input logic [7:0] s, input logic [7:0] t);
        int fb = 0;
        for (int i = 0; i < 8; i++) if (s[i] && t[i]) fb = 1 - fb;
        return 8'((int'(s) * 2 + fb) % 256);
    endfunction

    task automatic model_encrypt(input logic [7:0] t, input logic [7:0] s0, input int pre);
        logic [7:0] s = s0;
        g_exp.delete();
        for (int p = 0; p < FRAME_LEN; p++) begin
            if (p >= pre && p < pre + MSG_LEN) g_exp.push_back(g_msg[p-pre] ^ s);
            else g_exp.push_back(8'h20 ^ s);
            s = model_step(s, t);
        end
    endtask

    task automatic model_decrypt(input logic [7:0] t, input logic [7:0] s0, input int pre);
        logic [7:0] s = s0;
        logic [7:0] b;
        bit lead = 1'b1;
        g_exp.delete();
        for (int p = 0; p < FRAME_LEN; p++) begin
            if (p >= pre && p < pre + MSG_LEN) begin
                b = g_frame[p] ^ s;
                if (!(STRIP && lead && b == 8'h20)) begin
                    lead = 1'b0;
                    g_exp.push_back(b);
                end
            end
            s = model_step(s, t);
        end
    endtask

    task automatic set_msg(input string str);
        g_msg.delete();
        for (int i = 0; i < str.len(); i++) g_msg.push_back(str[i]);
    endtask

    // Drives one frame from g_in, collects accepted output bytes into g_out.
    task automatic run_frame(input bit m, input logic [7:0] t, input logic [7:0] s0, input logic [7:0] pre,
                             input int rdy_mode, input int gap_at, input int mid_start_at);
        int idx = 0, cyc = 0, gap = 0;
        bit prev_stall = 1'b0, seen_done = 1'b0;
        logic [7:0] prev_data = '0;
        g_out.delete();
        r_stall_err = 0; r_done_cnt = 0; r_busy_after = -1; r_timeout = 1'b0;
        @(posedge CLK); #1;
        start = 1'b1; mode = m; taps = t; seed = s0; pre_len = pre;
        @(posedge CLK); #1;
        start = 1'b0; taps = ~t; seed = ~s0; pre_len = 8'd200;
        while (1) begin
            cyc++;
            if (cyc > 2000) begin r_timeout = 1'b1; break; end
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (gap_at >= 0 && idx == gap_at && gap < 5) begin
                in_valid = 1'b0;
                gap++;
            end else begin
                in_valid = (idx < g_in.size()) && (rdy_mode < 2 || $urandom_range(0, 3) != 0);
            end
            in_data = (idx < g_in.size()) ? g_in[idx] : 8'($urandom);
            start = (cyc == mid_start_at);
            if (start) begin seed = 8'ha5; mode = ~m; end
            @(negedge CLK);
            if (seen_done) begin r_busy_after = int'(busy); break; end
            if (prev_stall && (!out_valid || out_data !== prev_data)) r_stall_err++;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) g_out.push_back(out_data);
            if (in_valid && in_ready) idx++;
            if (done) begin r_done_cnt++; seen_done = 1'b1; end
            @(posedge CLK); #1;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_checks++; if (out_count !== 8'd0) begin n_fail++; $display("FAIL reset_out_count got %0d want 0", out_count); end
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    task automatic test_encrypt();
        logic [7:0] first4[4];
        first4 = '{8'h21, 8'h22, 8'h24, 8'h29};
        set_msg("Mr. Watson, come here. I want to see you.");
        g_in = g_msg;
        model_encrypt(8'hd4, 8'h01, 9);
        run_frame(1'b0, 8'hd4, 8'h01, 8'd9, 0, -1, -1);
        n_checks++; if (r_timeout) begin n_fail++; $display("FAIL enc_timeout got timeout want done"); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (g_out[i] !== first4[i]) begin n_fail++; $display("FAIL enc_first[%0d] got %h want %h", i, g_out[i], first4[i]); end
        end
        n_checks++; if (g_out.size() != FRAME_LEN) begin n_fail++; $display("FAIL enc_len got %0d want %0d", g_out.size(), FRAME_LEN); end
        for (int i = 0; i < g_exp.size(); i++) begin
            n_checks++;
            if (g_out[i] !== g_exp[i]) begin n_fail++; $display("FAIL enc_byte[%0d] got %h want %h", i, g_out[i], g_exp[i]); end
        end
        n_checks++; if (r_done_cnt != 1) begin n_fail++; $display("FAIL enc_done_pulses got %0d want 1", r_done_cnt); end
        n_checks++; if (out_count !== 8'd64) begin n_fail++; $display("FAIL enc_out_count got %0d want 64", out_count); end
        n_checks++; if (r_busy_after != 0) begin n_fail++; $display("FAIL enc_busy_after_done got %0d want 0", r_busy_after); end
        g_frame = g_exp;
    endtask

    task automatic test_decrypt();
        g_in = g_frame;
        run_frame(1'b1, 8'hd4, 8'h01, 8'd9, 0, -1, -1);
        n_checks++; if (r_timeout) begin n_fail++; $display("FAIL dec_timeout got timeout want done"); end
        n_checks++; if (g_out.size() != MSG_LEN) begin n_fail++; $display("FAIL dec_len got %0d want %0d", g_out.size(), MSG_LEN); end
        for (int i = 0; i < MSG_LEN; i++) begin
            n_checks++;
            if (g_out[i] !== g_msg[i]) begin n_fail++; $display("FAIL dec_byte[%0d] got %h want %h", i, g_out[i], g_msg[i]); end
        end
        n_checks++; if (out_count !== 8'd41) begin n_fail++; $display("FAIL dec_out_count got %0d want 41", out_count); end
        n_checks++; if (r_done_cnt != 1) begin n_fail++; $display("FAIL dec_done_pulses got %0d want 1", r_done_cnt); end
    endtask

    task automatic test_strip();
        logic [7:0] exp_first, exp_cnt;
        exp_first = STRIP ? 8'h66 : 8'h20;
        exp_cnt   = STRIP ? 8'd39 : 8'd41;
        set_msg("  f       A joke is a very serious thing.");
        model_encrypt(8'hfa, 8'h3c, 10);
        g_frame = g_exp;
        model_decrypt(8'hfa, 8'h3c, 10);
        g_in = g_frame;
        run_frame(1'b1, 8'hfa, 8'h3c, 8'd10, 0, -1, -1);
        n_checks++; if (r_timeout) begin n_fail++; $display("FAIL strip_timeout got timeout want done"); end
        n_checks++; if (g_out[0] !== exp_first) begin n_fail++; $display("FAIL strip_first got %h want %h", g_out[0], exp_first); end
        n_checks++; if (out_count !== exp_cnt) begin n_fail++; $display("FAIL strip_out_count got %0d want %0d", out_count, exp_cnt); end
        n_checks++; if (g_out.size() != g_exp.size()) begin n_fail++; $display("FAIL strip_len got %0d want %0d", g_out.size(), g_exp.size()); end
        for (int i = 0; i < g_exp.size(); i++) begin
            n_checks++;
            if (g_out[i] !== g_exp[i]) begin n_fail++; $display("FAIL strip_byte[%0d] got %h want %h", i, g_out[i], g_exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        set_msg("Mr. Watson, come here. I want to see you.");
        g_in = g_msg;
        model_encrypt(8'hd4, 8'h01, 9);
        run_frame(1'b0, 8'hd4, 8'h01, 8'd9, 1, 20, -1);
        n_checks++; if (r_timeout) begin n_fail++; $display("FAIL bp_timeout got timeout want done"); end
        n_checks++; if (r_stall_err != 0) begin n_fail++; $display("FAIL bp_stall_stable got %0d changes want 0", r_stall_err); end
        n_checks++; if (g_out.size() != FRAME_LEN) begin n_fail++; $display("FAIL bp_len got %0d want %0d", g_out.size(), FRAME_LEN); end
        for (int i = 0; i < g_exp.size(); i++) begin
            n_checks++;
            if (g_out[i] !== g_exp[i]) begin n_fail++; $display("FAIL bp_byte[%0d] got %h want %h", i, g_out[i], g_exp[i]); end
        end
        n_checks++; if (out_count !== 8'd64) begin n_fail++; $display("FAIL bp_out_count got %0d want 64", out_count); end
    endtask

    task automatic test_config_err();
        bit saw_io = 1'b0;
        @(posedge CLK); #1;
        start = 1'b1; mode = 1'b0; taps = 8'hd4; seed = 8'h01; pre_len = 8'd24;
        in_valid = 1'b1; in_data = 8'h41; out_ready = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        @(negedge CLK);
        saw_io = saw_io | in_ready | out_valid;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL cfg_done_n1 got %b want 0", done); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL cfg_err got %b want 1", err); end
        @(posedge CLK); #1;
        @(negedge CLK);
        saw_io = saw_io | in_ready | out_valid;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL cfg_done_n2 got %b want 1", done); end
        n_checks++; if (saw_io) begin n_fail++; $display("FAIL cfg_no_io got traffic want none"); end
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cfg_busy_after got %b want 0", busy); end
        n_checks++; if (out_count !== 8'd0) begin n_fail++; $display("FAIL cfg_out_count got %0d want 0", out_count); end
        in_valid = 1'b0;
        set_msg("Mr. Watson, come here. I want to see you.");
        g_in = g_msg;
        model_encrypt(8'h8e, 8'h77, 23);
        run_frame(1'b0, 8'h8e, 8'h77, 8'd23, 0, -1, -1);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_cleared got %b want 0", err); end
        n_checks++; if (g_out.size() != FRAME_LEN) begin n_fail++; $display("FAIL cfg_pre23_len got %0d want %0d", g_out.size(), FRAME_LEN); end
        for (int i = 0; i < g_exp.size(); i++) begin
            n_checks++;
            if (g_out[i] !== g_exp[i]) begin n_fail++; $display("FAIL cfg_pre23_byte[%0d] got %h want %h", i, g_out[i], g_exp[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int idx = 0, cnt = 0;
        set_msg("Mr. Watson, come here. I want to see you.");
        @(posedge CLK); #1;
        start = 1'b1; mode = 1'b0; taps = 8'hb8; seed = 8'h5e; pre_len = 8'd4;
        @(posedge CLK); #1;
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 200 && cnt < 20; c++) begin
            in_data = g_msg[idx % MSG_LEN];
            @(negedge CLK);
            if (out_valid && out_ready) cnt++;
            if (in_valid && in_ready) idx++;
            @(posedge CLK); #1;
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        n_checks++; if (cnt != 20) begin n_fail++; $display("FAIL rst_mid_reach20 got %0d want 20", cnt); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_ready got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_out_data got %h want 00", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_checks++; if (out_count !== 8'd0) begin n_fail++; $display("FAIL rst_mid_out_count got %0d want 0", out_count); end
        in_valid = 1'b0;
        for (int i = 0; i < MSG_LEN; i++) g_msg[i] = 8'($urandom);
        g_in = g_msg;
        model_encrypt(8'hb8, 8'h5e, 4);
        run_frame(1'b0, 8'hb8, 8'h5e, 8'd4, 0, -1, 15);
        n_checks++; if (g_out.size() != FRAME_LEN) begin n_fail++; $display("FAIL rst_mid_len got %0d want %0d", g_out.size(), FRAME_LEN); end
        for (int i = 0; i < g_exp.size(); i++) begin
            n_checks++;
            if (g_out[i] !== g_exp[i]) begin n_fail++; $display("FAIL rst_mid_byte[%0d] got %h want %h", i, g_out[i], g_exp[i]); end
        end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_start_ignored got err=%b want 0", err); end
    endtask

    task automatic test_random();
        logic [7:0] t, s, pre;
        for (int it = 0; it < 6; it++) begin
            t   = 8'($urandom);
            s   = (it == 0) ? 8'h00 : 8'($urandom);
            pre = (it == 1) ? 8'd0 : (it == 2) ? 8'd23 : 8'($urandom_range(0, 23));
            for (int i = 0; i < MSG_LEN; i++) g_msg[i] = ($urandom_range(0, 3) == 0) ? 8'h20 : 8'($urandom);
            model_encrypt(t, s, int'(pre));
            g_frame = g_exp;
            g_in = g_msg;
            run_frame(1'b0, t, s, pre, 2, -1, -1);
            n_checks++; if (r_timeout) begin n_fail++; $display("FAIL rnd_enc_timeout it=%0d got timeout want done", it); end
            n_checks++; if (r_stall_err != 0) begin n_fail++; $display("FAIL rnd_enc_stall it=%0d got %0d want 0", it, r_stall_err); end
            n_checks++; if (g_out.size() != FRAME_LEN) begin n_fail++; $display("FAIL rnd_enc_len it=%0d got %0d want %0d", it, g_out.size(), FRAME_LEN); end
            for (int i = 0; i < FRAME_LEN; i++) begin
                n_checks++;
                if (g_out[i] !== g_frame[i]) begin n_fail++; $display("FAIL rnd_enc_byte it=%0d [%0d] got %h want %h", it, i, g_out[i], g_frame[i]); end
            end
            model_decrypt(t, s, int'(pre));
            g_in = g_frame;
            run_frame(1'b1, t, s, pre, 2, -1, -1);
            n_checks++; if (r_timeout) begin n_fail++; $display("FAIL rnd_dec_timeout it=%0d got timeout want done", it); end
            n_checks++; if (g_out.size() != g_exp.size()) begin n_fail++; $display("FAIL rnd_dec_len it=%0d got %0d want %0d", it, g_out.size(), g_exp.size()); end
            for (int i = 0; i < g_exp.size(); i++) begin
                n_checks++;
                if (g_out[i] !== g_exp[i]) begin n_fail++; $display("FAIL rnd_dec_byte it=%0d [%0d] got %h want %h", it, i, g_out[i], g_exp[i]); end
            end
            n_checks++; if (int'(out_count) != g_exp.size()) begin n_fail++; $display("FAIL rnd_dec_count it=%0d got %0d want %0d", it, out_count, g_exp.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_strip();
        test_backpressure();
        test_config_err();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
